// File: rtl/logger_pkg.sv
// Shared types and helpers for the logger drain path: dump FSM states and
// the ASCII rendering of entry nibbles.
package logger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CAPTURE,
    ST_LOAD,
    ST_SEND,
    ST_FINISH
  } dump_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Upper-case hex digit.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    hex2ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit, each
// held CLK_DIV cycles. txd is registered and idles high.
module uart_tx_byte #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLK_DIV - 2);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    sh;
  logic          active;
  logic          bit_end;
  logic          last;
  logic          accept;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign last    = active && (bit_cnt == 4'd9) && bit_end;
  // done fires one cycle before the stop bit ends so the caller can queue
  // the next byte into the final stop cycle and keep frames gapless.
  assign done    = active && (bit_cnt == 4'd9) && (baud_cnt == BAUD_PRE);
  assign busy    = active;
  assign accept  = start && (!active || last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd      <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
    end else if (accept) begin
      active   <= 1'b1;
      txd      <= 1'b0;
      sh       <= {1'b1, data};
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          txd     <= sh[0];
          sh      <= {1'b1, sh[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/logger_dump_tx.sv
// Logger drain: pops every buffered entry and streams it as upper-case hex
// plus CR LF over an 8N1 UART.
module logger_dump_tx
  import logger_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int CLK_DIV    = 434
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  input  logic                  buf_empty,
  output logic                  buf_rd_en,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  output logic                  uart_txd,
  output logic                  busy,
  output logic                  done
);

  localparam int NIB = (DATA_WIDTH + 3) / 4;
  localparam int SHW = NIB * 4;
  localparam int IW  = $clog2(NIB + 2);

  dump_state_e    state, state_nxt;
  logic           start_q;
  logic [SHW-1:0] ent_sh;
  logic [IW-1:0]  idx;
  logic           cap;
  logic           idx_inc;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           tx_done;

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  (tx_data),
    .txd   (uart_txd),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  // Accepted start is registered first; this gives busy one cycle after
  // rd_start and keeps the pop strobe a cycle later, where it is combinational
  // on buf_empty.
  assign busy = start_q || (state != ST_IDLE);

  always_comb begin
    if (idx < IW'(NIB))      tx_data = hex2ascii(ent_sh[SHW-1 -: 4]);
    else if (idx == IW'(NIB)) tx_data = ASCII_CR;
    else                      tx_data = ASCII_LF;
  end

  always_comb begin
    state_nxt = state;
    buf_rd_en = 1'b0;
    tx_start  = 1'b0;
    done      = 1'b0;
    cap       = 1'b0;
    idx_inc   = 1'b0;
    case (state)
      ST_IDLE:    if (start_q) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (buf_empty) begin
          state_nxt = ST_FINISH;
        end else begin
          buf_rd_en = 1'b1;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        cap       = 1'b1;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        tx_start  = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done && tx_busy) begin
          if (idx < IW'(NIB + 1)) begin
            idx_inc   = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_CHECK;
          end
        end
      end
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
      ent_sh  <= '0;
      idx     <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= rd_start && (state == ST_IDLE) && !start_q;
      if (cap) begin
        ent_sh <= SHW'(buf_rd_data);
        idx    <= '0;
      end else begin
        if (tx_start && (idx < IW'(NIB))) ent_sh <= ent_sh << 4;
        if (idx_inc) idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_logger_dump_tx.sv
// Bench for logger_dump_tx: logger model, UART frame decoder and a byte
// scoreboard fed when entries are queued.
module tb_logger_dump_tx;

  localparam int DW  = 36;
  localparam int CD  = 4;
  localparam int NIB = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_start = 1'b0;
  logic          buf_empty = 1'b1;
  logic          buf_rd_en;
  logic [DW-1:0] buf_rd_data = '0;
  logic          uart_txd;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  logger_dump_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_start    (rd_start),
    .buf_empty   (buf_empty),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_data (buf_rd_data),
    .uart_txd    (uart_txd),
    .busy        (busy),
    .done        (done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0, pop_cnt = 0, bytes_rx = 0, txd_low_cnt = 0;
  int busy_rise_cyc = 0;
  logic busy_d = 1'b0, rd_en_d = 1'b0;

  logic [DW-1:0] lq[$];
  logic [DW-1:0] wr_q[$];
  logic [7:0]    exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Logger read port: registered read data, one cycle after the pop strobe.
  always @(posedge clk) begin
    if (buf_rd_en && lq.size() > 0) buf_rd_data <= lq.pop_front();
    while (wr_q.size() > 0) lq.push_back(wr_q.pop_front());
    buf_empty <= (lq.size() == 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (buf_rd_en) begin
        pop_cnt++;
        chk("rd_en_while_empty", buf_empty, 0);
        chk("rd_en_back2back", rd_en_d, 0);
      end
      if (busy && !busy_d) busy_rise_cyc = cyc;
      if (!uart_txd) txd_low_cnt++;
    end
    busy_d  = busy;
    rd_en_d = buf_rd_en;
  end

  // Frame decoder: every bit must hold one level for exactly CD samples.
  initial begin : mon
    logic       prev;
    logic [9:0] bits;
    logic       ok, ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !uart_txd) begin
        bits = '0;
        ok   = 1'b1;
        ab   = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < CD; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (!rst_n) ab = 1'b1;
            if (s == 0) bits[b] = uart_txd;
            else if (uart_txd !== bits[b]) ok = 1'b0;
          end
        end
        prev = uart_txd;
        if (!ab) begin
          bytes_rx++;
          chk("frame_timing", ok, 1);
          chk("start_bit", bits[0], 0);
          chk("stop_bit", bits[9], 1);
          if (bits[8:1] == 8'h41) chk("bits_0x41", bits, 10'b1010000010);
          chk("rx_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("rx_byte", bits[8:1], exp_q.pop_front());
        end
      end else begin
        prev = uart_txd;
      end
    end
  end

  task automatic push_entry(input logic [DW-1:0] e, input bit with_exp);
    wr_q.push_back(e);
    if (with_exp) begin
      for (int i = NIB - 1; i >= 0; i--) begin
        logic [3:0] n;
        n = e[4*i +: 4];
        exp_q.push_back(n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n});
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic pulse_start(output int k);
    @(negedge clk);
    rd_start = 1'b1;
    k = cyc;
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim, output int dc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, got, 1);
    dc = cyc;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, k2, dc, d0, p0, b0, t0, lat;

    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single entry
    push_entry(36'h12345ABCD, 1);
    repeat (3) @(negedge clk);
    d0 = done_cnt; p0 = pop_cnt; b0 = bytes_rx;
    pulse_start(k);
    chk("t1_busy_next", busy, 1);
    wait_done("t1_done_seen", 2000, dc);
    lat = dc - busy_rise_cyc;
    chk("t1_latency", (lat >= 440 && lat <= 449), 1);
    repeat (10) @(negedge clk);
    chk("t1_dones", done_cnt - d0, 1);
    chk("t1_pops", pop_cnt - p0, 1);
    chk("t1_bytes", bytes_rx - b0, 11);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_idle", busy, 0);

    // empty logger
    d0 = done_cnt; p0 = pop_cnt; t0 = txd_low_cnt;
    pulse_start(k);
    chk("t2_busy_next", busy, 1);
    wait_done("t2_done_seen", 20, dc);
    chk("t2_done_cycle", dc - k, 3);
    @(negedge clk);
    chk("t2_busy_clear", busy, 0);
    repeat (5) @(negedge clk);
    chk("t2_pops", pop_cnt - p0, 0);
    chk("t2_txd_high", txd_low_cnt - t0, 0);
    chk("t2_dones", done_cnt - d0, 1);

    // three entries, with a stray rd_start mid-dump
    push_entry(36'h0, 1);
    push_entry(36'hFFFFFFFFF, 1);
    push_entry(36'h00000000A, 1);
    repeat (3) @(negedge clk);
    d0 = done_cnt; p0 = pop_cnt; b0 = bytes_rx;
    pulse_start(k);
    repeat (100) @(negedge clk);
    pulse_start(k2);
    wait_done("t3_done_seen", 3000, dc);
    repeat (60) @(negedge clk);
    chk("t3_dones", done_cnt - d0, 1);
    chk("t3_pops", pop_cnt - p0, 3);
    chk("t3_bytes", bytes_rx - b0, 33);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_idle", busy, 0);

    // reset during 5th data bit of the first character
    push_entry(36'h0DEADBEEF, 0);
    push_entry(36'h987654321, 1);
    repeat (3) @(negedge clk);
    d0 = done_cnt; p0 = pop_cnt; b0 = bytes_rx;
    pulse_start(k);
    for (int i = 0; i < 20; i++) begin
      if (!uart_txd) break;
      @(negedge clk);
    end
    chk("t6_start_seen", uart_txd, 0);
    repeat (21) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_txd", uart_txd, 1);
    chk("t6_rst_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("t6_rst_rd_en", buf_rd_en, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_pops_before", pop_cnt - p0, 1);
    chk("t6_idle_txd", uart_txd, 1);
    pulse_start(k);
    wait_done("t6_done_seen", 2000, dc);
    repeat (10) @(negedge clk);
    chk("t6_dones", done_cnt - d0, 1);
    chk("t6_pops", pop_cnt - p0, 2);
    chk("t6_bytes", bytes_rx - b0, 11);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_logger_empty", lq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
